svreal_arith_sched: RTL and testbench
=====================================

Name: svreal_arith_sched

Overview:
- Shares one pipelined svreal arithmetic datapath (MUL/ADD/SUB/MIN/MAX) among N_REQ requesters.
- Arbitration is round-robin; the datapath has a 2-stage registered pipeline with full valid/ready backpressure.
- Each requester presents two significands in a common input format; results return tagged with the requester id in a common output format.
- Sits between control FSMs that each need occasional real arithmetic and the one shared arithmetic unit in the fixed-point (non-SVREAL_DEBUG) build.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- W_IN, 16, signed significand width of operands a and b.
- EXP_IN, -8, exponent of operands a and b.
- W_OUT, 16, signed significand width of the result.
- EXP_OUT, -8, exponent of the result.
- ID_W, $clog2(N_REQ), width of the requester tag.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, N_REQ, request valid per requester.
- req_ready, out, N_REQ, request accepted this cycle when valid&&ready.
- req_opcode, in, N_REQ*3, packed opcodes, requester i at [3i+2:3i].
- req_a, in, N_REQ*W_IN, packed signed operand a significands.
- req_b, in, N_REQ*W_IN, packed signed operand b significands.
- rsp_valid, out, 1, result valid.
- rsp_ready, in, 1, downstream accepts the result.
- rsp_id, out, ID_W, index of the requester that issued the result.
- rsp_value, out, W_OUT, signed result significand at EXP_OUT.
- rsp_err, out, 1, illegal opcode flag.

Behaviour:
- Reset (async assert, sync use): all stage valids 0, rsp_valid=0, rsp_id=0, rsp_value=0, rsp_err=0, rr pointer=N_REQ-1 (requester 0 has first priority). Reset mid-operation drops in-flight ops silently.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i], searching ptr+1, ptr+2, … with wrap at N_REQ.
  - req_ready[i]=grant[i] && s1_free, where s1_free = !s1_valid || s1_advance.
  - At most one req_ready is high per cycle.
  - ptr <= granted index only on an accepted handshake.
- Stage 1 (S1): registers opcode, a, b and id on accept.
- Stage 2 (S2): registers the computed result.
  - S1 advances when !s2_valid || (rsp_valid && rsp_ready).
  - rsp_valid = s2_valid; rsp_* are driven from S2 registers.
- Latency: handshake in cycle T gives rsp_valid in cycle T+2. Throughput is 1 op/cycle with rsp_ready held high.
- Backpressure: while rsp_ready=0, S2 holds and S1 fills. At most 2 ops are buffered, then all req_ready=0. rsp_* stay stable while rsp_valid && !rsp_ready.
- Arithmetic (computed combinationally between S1 and S2):
  - opcodes: 0 MUL, 1 ADD, 2 SUB, 3 MIN, 4 MAX.
  - ADD/SUB: (W_IN+1)-bit exact sum at EXP_IN, then shift by EXP_IN-EXP_OUT.
  - MUL: 2*W_IN-bit product at 2*EXP_IN, then shift by 2*EXP_IN-EXP_OUT.
  - MIN/MAX: signed compare of a and b; tie selects a; selected value shifted by EXP_IN-EXP_OUT.
  - Shift direction: positive shift is a left shift; negative shift is an arithmetic right shift (floor).
  - Narrowing to W_OUT: keep the low W_OUT bits (wrap), unless the optional feature is enabled.
  - Opcodes 5..7: rsp_value=0, rsp_err=1. The op still occupies a pipeline slot and returns its id.

Optional Feature:
- Macro: SVREAL_SCHED_SAT_EN.
- Defined: the wide intermediate is saturated to [-2^(W_OUT-1), 2^(W_OUT-1)-1] before narrowing, including bits lost by a left shift.
- Undefined: plain truncation (wrap); no saturation logic is instantiated.

Decomposition:
- Package svreal_sched_pkg:
  - opcode localparams OP_MUL=0, OP_ADD=1, OP_SUB=2, OP_MIN=3, OP_MAX=4, numerically identical to the existing SVREAL_OPCODE_* macros.
  - typedef logic [2:0] svreal_op_t.
  - function that computes the signed shift amount.
- Sub-module svreal_rr_arbiter, parameterised on N_REQ:
  - inputs: req vector, ptr, advance strobe.
  - outputs: one-hot grant, granted index, updated pointer register.
- The datapath stays inline.

Test Plan (W_IN=W_OUT=16, EXP_IN=EXP_OUT=-8, i.e. 1.0=256):
- Req 0 ADD a=384, b=128, accepted cycle T -> rsp_valid at T+2, rsp_id=0, rsp_value=512, rsp_err=0.
- Req 2 MUL a=384, b=512 -> rsp_value=768 (3.0); MIN a=-256, b=100 -> -256; MAX tie a=b=50 -> 50.
- All 4 req_valid held high, rsp_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; one rsp per cycle in the same order.
- rsp_ready=0 for 5 cycles with req 1 always valid -> exactly 2 accepted; rsp_* stable throughout; after release both return in order and none are lost.
- ADD 32767+32767 -> 32767 with SVREAL_SCHED_SAT_EN defined, -2 without; opcode 6 -> rsp_value=0, rsp_err=1.
- rst_n pulsed low while S1 and S2 are valid -> rsp_valid=0 immediately (asynchronous); after release, req 3 and req 0 both valid -> req 0 granted first.

Source files
------------

// File: rtl/svreal_sched_pkg.sv
// Shared opcode encoding and exponent helpers for the svreal arithmetic scheduler.
package svreal_sched_pkg;

    typedef logic [2:0] svreal_op_t;

    // Values match the SVREAL_OPCODE_* macros used elsewhere in the codebase.
    localparam svreal_op_t OP_MUL = 3'd0;
    localparam svreal_op_t OP_ADD = 3'd1;
    localparam svreal_op_t OP_SUB = 3'd2;
    localparam svreal_op_t OP_MIN = 3'd3;
    localparam svreal_op_t OP_MAX = 3'd4;

    // Positive result means a left shift is needed to move from exp_src to exp_dst.
    function automatic int shift_amt(input int exp_src, input int exp_dst);
        return exp_src - exp_dst;
    endfunction

endpackage

// File: rtl/svreal_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 with wrap; the pointer moves only on an accepted grant.
module svreal_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic [ID_W-1:0]  ptr_nxt
);

    int   j;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

    assign ptr_nxt = advance ? idx : ptr;

endmodule

// File: rtl/svreal_arith_sched.sv
// Round-robin shared 2-stage svreal arithmetic unit (MUL/ADD/SUB/MIN/MAX) with valid/ready flow.
// Define SVREAL_SCHED_SAT_EN to saturate results instead of wrapping on narrowing.
module svreal_arith_sched
    import svreal_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W_IN    = 16,
    parameter int EXP_IN  = -8,
    parameter int W_OUT   = 16,
    parameter int EXP_OUT = -8,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*3-1:0]        req_opcode,
    input  logic [N_REQ*W_IN-1:0]     req_a,
    input  logic [N_REQ*W_IN-1:0]     req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic signed [W_OUT-1:0]   rsp_value,
    output logic                      rsp_err
);

    localparam int SH_LIN  = shift_amt(EXP_IN, EXP_OUT);
    localparam int SH_MUL  = shift_amt(2*EXP_IN, EXP_OUT);
    localparam int SH_UP   = (SH_LIN > SH_MUL) ? ((SH_LIN > 0) ? SH_LIN : 0)
                                               : ((SH_MUL > 0) ? SH_MUL : 0);
    localparam int WIDE_A  = 2*W_IN + 2 + SH_UP;
    // Wide enough that no left shift or product ever loses bits before narrowing.
    localparam int WIDE    = (WIDE_A > W_OUT + 1) ? WIDE_A : W_OUT + 1;

    function automatic logic signed [WIDE-1:0] shift_w(input logic signed [WIDE-1:0] x,
                                                        input int sh);
        if (sh >= 0) return x <<< sh;
        return x >>> (-sh);
    endfunction

`ifdef SVREAL_SCHED_SAT_EN
    localparam logic signed [WIDE-1:0] SAT_HI = {{(WIDE-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [WIDE-1:0] SAT_LO = ~SAT_HI;

    function automatic logic signed [W_OUT-1:0] narrow(input logic signed [WIDE-1:0] x);
        if (x > SAT_HI) return W_OUT'(SAT_HI);
        if (x < SAT_LO) return W_OUT'(SAT_LO);
        return W_OUT'(x);
    endfunction
`else
    function automatic logic signed [W_OUT-1:0] narrow(input logic signed [WIDE-1:0] x);
        return W_OUT'(x);
    endfunction
`endif

    logic [N_REQ-1:0]        grant;
    logic [ID_W-1:0]         gnt_idx;
    logic [ID_W-1:0]         ptr_q;
    logic [ID_W-1:0]         ptr_nxt;
    logic                    accept;
    logic                    s1_adv;
    logic                    s1_free;

    logic                    vld_p1;
    svreal_op_t              op_p1;
    logic signed [W_IN-1:0]  a_p1;
    logic signed [W_IN-1:0]  b_p1;
    logic [ID_W-1:0]         id_p1;

    logic                    vld_p2;
    logic signed [W_OUT-1:0] value_p2;
    logic [ID_W-1:0]         id_p2;
    logic                    err_p2;

    logic signed [WIDE-1:0]  a_w;
    logic signed [WIDE-1:0]  b_w;
    logic signed [WIDE-1:0]  res_w;
    logic signed [W_OUT-1:0] value_c;
    logic                    err_c;

    svreal_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .advance (accept),
        .grant   (grant),
        .idx     (gnt_idx),
        .ptr_nxt (ptr_nxt)
    );

    assign s1_adv    = !vld_p2 || rsp_ready;
    assign s1_free   = !vld_p1 || s1_adv;
    assign accept    = s1_free && (|grant);
    assign req_ready = grant & {N_REQ{s1_free}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= ID_W'(N_REQ - 1);
        else        ptr_q <= ptr_nxt;
    end

    // Stage 1: capture the granted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       vld_p1 <= 1'b0;
        else if (s1_free) vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_p1 <= req_opcode[gnt_idx*3 +: 3];
            a_p1  <= req_a[gnt_idx*W_IN +: W_IN];
            b_p1  <= req_b[gnt_idx*W_IN +: W_IN];
            id_p1 <= gnt_idx;
        end
    end

    always_comb begin
        a_w   = WIDE'(a_p1);
        b_w   = WIDE'(b_p1);
        res_w = '0;
        err_c = 1'b0;
        case (op_p1)
            OP_MUL:  res_w = shift_w(a_w * b_w, SH_MUL);
            OP_ADD:  res_w = shift_w(a_w + b_w, SH_LIN);
            OP_SUB:  res_w = shift_w(a_w - b_w, SH_LIN);
            OP_MIN:  res_w = shift_w((b_w < a_w) ? b_w : a_w, SH_LIN);
            OP_MAX:  res_w = shift_w((b_w > a_w) ? b_w : a_w, SH_LIN);
            default: err_c = 1'b1;
        endcase
        value_c = err_c ? '0 : narrow(res_w);
    end

    // Stage 2: result register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            id_p2    <= '0;
            value_p2 <= '0;
            err_p2   <= 1'b0;
        end else if (s1_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                id_p2    <= id_p1;
                value_p2 <= value_c;
                err_p2   <= err_c;
            end
        end
    end

    assign rsp_valid = vld_p2;
    assign rsp_id    = id_p2;
    assign rsp_value = value_p2;
    assign rsp_err   = err_p2;

endmodule

// File: tb/tb_svreal_arith_sched.sv
// Directed bench for svreal_arith_sched: vector table plus round-robin, backpressure and reset sequences.
module tb_svreal_arith_sched;

    localparam int N_REQ = 4;
    localparam int W_IN  = 16;
    localparam int W_OUT = 16;
    localparam int ID_W  = 2;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*3-1:0]      req_opcode;
    logic [N_REQ*W_IN-1:0]   req_a;
    logic [N_REQ*W_IN-1:0]   req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic signed [W_OUT-1:0] rsp_value;
    logic                    rsp_err;

    svreal_arith_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_value  (rsp_value),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int op;
        int a;
        int b;
        int val;
        int err;
    } vec_t;

    int n_cmp;
    int n_bad;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input int op, input int a, input int b);
        logic [2:0]      op3;
        logic [W_IN-1:0] a16;
        logic [W_IN-1:0] b16;
        op3 = 3'(op);
        a16 = W_IN'(a);
        b16 = W_IN'(b);
        req_valid[id]             = 1'b1;
        req_opcode[id*3 +: 3]     = op3;
        req_a[id*W_IN +: W_IN]    = a16;
        req_b[id*W_IN +: W_IN]    = b16;
    endtask

    vec_t vecs[12];
    int   acc;
    logic [ID_W-1:0]         snap_id;
    logic signed [W_OUT-1:0] snap_val;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;

        vecs[0]  = '{0, 1, 384, 128, 512, 0};
        vecs[1]  = '{2, 0, 384, 512, 768, 0};
        vecs[2]  = '{2, 3, -256, 100, -256, 0};
        vecs[3]  = '{2, 4, 50, 50, 50, 0};
        vecs[4]  = '{1, 2, 100, 300, -200, 0};
        vecs[5]  = '{0, 0, -1, 1, -1, 0};
        vecs[6]  = '{1, 0, 1, 1, 0, 0};
        vecs[7]  = '{2, 4, -5, 3, 3, 0};
`ifdef SVREAL_SCHED_SAT_EN
        vecs[8]  = '{0, 1, 32767, 32767, 32767, 0};
        vecs[9]  = '{1, 2, -32768, 32767, -32768, 0};
`else
        vecs[8]  = '{0, 1, 32767, 32767, -2, 0};
        vecs[9]  = '{1, 2, -32768, 32767, 1, 0};
`endif
        vecs[10] = '{0, 0, -384, 512, -768, 0};
        vecs[11] = '{3, 6, 5, 5, 0, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_id", rsp_id, 0);
        chk("reset rsp_value", rsp_value, 0);
        chk("reset rsp_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            set_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
            chk($sformatf("vec%0d req_ready", i), req_ready, 1 << vecs[i].id);
            @(posedge clk);
            #1;
            req_valid = '0;
            @(negedge clk);
            chk($sformatf("vec%0d rsp_valid T+1", i), rsp_valid, 0);
            @(negedge clk);
            chk($sformatf("vec%0d rsp_valid T+2", i), rsp_valid, 1);
            chk($sformatf("vec%0d rsp_id", i), rsp_id, vecs[i].id);
            chk($sformatf("vec%0d rsp_value", i), rsp_value, vecs[i].val);
            chk($sformatf("vec%0d rsp_err", i), rsp_err, vecs[i].err);
            @(posedge clk);
            #1;
        end

        // Round robin with all requesters busy; pointer last moved to 3.
        for (int r = 0; r < N_REQ; r++) set_req(r, 1, r + 1, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d grant", k), req_ready, 1 << (k % 4));
            chk($sformatf("rr%0d rsp_valid", k), rsp_valid, (k >= 2) ? 1 : 0);
            if (k >= 2) begin
                chk($sformatf("rr%0d rsp_id", k), rsp_id, (k - 2) % 4);
                chk($sformatf("rr%0d rsp_value", k), rsp_value, (k - 2) % 4 + 1);
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        for (int k = 8; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d drain id", k), rsp_id, (k - 2) % 4);
            chk($sformatf("rr%0d drain valid", k), rsp_valid, 1);
            @(posedge clk);
            #1;
        end

        // Backpressure: consumer stalls, requester 1 keeps asking.
        rsp_ready = 1'b0;
        acc = 0;
        set_req(1, 1, 10, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (req_ready[1]) acc++;
            if (k == 2) begin
                snap_id  = rsp_id;
                snap_val = rsp_value;
                chk("bp first rsp value", rsp_value, 10);
                chk("bp first rsp id", rsp_id, 1);
            end
            if (k >= 2) begin
                chk($sformatf("bp%0d rsp_valid", k), rsp_valid, 1);
                chk($sformatf("bp%0d stable value", k), rsp_value, snap_val);
                chk($sformatf("bp%0d stable id", k), rsp_id, snap_id);
            end
            @(posedge clk);
            #1;
            set_req(1, 1, 10 + acc, 0);
        end
        chk("bp accepted count", acc, 2);
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release 1 valid", rsp_valid, 1);
        chk("bp release 1 value", rsp_value, 10);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp release 2 valid", rsp_valid, 1);
        chk("bp release 2 value", rsp_value, 11);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp drained", rsp_valid, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a stall with both stages occupied.
        rsp_ready = 1'b0;
        set_req(0, 1, 77, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset rsp_valid", rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset rsp_valid", rsp_valid, 0);
        chk("async reset rsp_value", rsp_value, 0);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(3, 1, 3, 0);
        set_req(0, 1, 4, 0);
        #1;
        chk("post-reset grant req0 first", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("post-reset grant req3 next", req_ready, 4'b1000);
        req_valid = '0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
